// File: rtl/conv_accum_relu.sv
// conv_accum_relu: sums TAPS signed tap products per beat, accumulates beats
// (channels) into one pixel, then shifts and clamps the pixel to OUT_WIDTH bits.
//
// Two-stage pipeline:
// - S1 registers the tap sum together with the beat's last/mode/shift.
// - S2 accumulates the beats and loads the clamped result into the output
//   register.
// Both stages advance together on en = !out_Valid || out_Ready.
//
// Ports:
//   in_Clk, in_Rst_N  clock (rising edge), asynchronous active-low reset
//   in_Data           TAPS packed signed taps, tap k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_Valid/in_Ready beat handshake; in_Ready is the pipeline enable
//   in_Last           final channel of the current pixel
//   in_Mode           0: clamp to [0, 2^OUT_WIDTH-1]; 1: signed OUT_WIDTH saturation
//   in_Shift          arithmetic right shift applied before the clamp
//   out_Sum/out_Valid/out_Ready  result handshake
//   out_Err           sticky channel-overflow flag
module conv_accum_relu #(
    parameter int DATA_WIDTH = 16,
    parameter int TAPS       = 9,
    parameter int OUT_WIDTH  = 8,
    parameter int CH_MAX     = 16
) (
    input  logic                       in_Clk,
    input  logic                       in_Rst_N,
    input  logic [TAPS*DATA_WIDTH-1:0] in_Data,
    input  logic                       in_Valid,
    input  logic                       in_Last,
    input  logic                       in_Mode,
    input  logic [3:0]                 in_Shift,
    output logic                       in_Ready,
    output logic [OUT_WIDTH-1:0]       out_Sum,
    output logic                       out_Valid,
    input  logic                       out_Ready,
    output logic                       out_Err
);

    localparam int ACC_WIDTH = DATA_WIDTH + $clog2(TAPS) + $clog2(CH_MAX) + 1;
    localparam int CNT_WIDTH = (CH_MAX > 1) ? $clog2(CH_MAX) : 1;

    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(CH_MAX - 1);

    localparam logic signed [ACC_WIDTH-1:0] UnsignedMax =
        ACC_WIDTH'((longint'(1) << OUT_WIDTH) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SignedMax =
        ACC_WIDTH'((longint'(1) << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SignedMin =
        ACC_WIDTH'(-(longint'(1) << (OUT_WIDTH - 1)));

    logic en;

    // S1 state
    logic                        s1_valid_q;
    logic signed [ACC_WIDTH-1:0] s1_sum_q;
    logic                        s1_last_q;
    logic                        s1_mode_q;
    logic [3:0]                  s1_shift_q;

    // S2 / output state
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic [CNT_WIDTH-1:0]        cnt_q;
    logic [OUT_WIDTH-1:0]        sum_q;
    logic                        valid_q;
    logic                        err_q;

    logic signed [ACC_WIDTH-1:0] tap_sum;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic [OUT_WIDTH-1:0]        clamped;
    logic                        overflow;
    logic                        close_pixel;

    assign en        = !valid_q || out_Ready;
    assign in_Ready  = en;
    assign out_Sum   = sum_q;
    assign out_Valid = valid_q;
    assign out_Err   = err_q;

    // Sign-extend every tap to the accumulator width before summing.
    always_comb begin
        tap_sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            tap_sum = tap_sum + ACC_WIDTH'($signed(in_Data[k*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_last_q  <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_shift_q <= '0;
        end else if (en) begin
            s1_valid_q <= in_Valid;
            if (in_Valid) begin
                s1_sum_q   <= tap_sum;
                s1_last_q  <= in_Last;
                s1_mode_q  <= in_Mode;
                s1_shift_q <= in_Shift;
            end
        end
    end

    // A full channel counter without last closes the pixel anyway, so the
    // result is never lost and the accumulator cannot run past its sizing.
    always_comb begin
        acc_next    = ((cnt_q == '0) ? '0 : acc_q) + s1_sum_q;
        overflow    = (cnt_q == CntLast) && !s1_last_q;
        close_pixel = s1_last_q || overflow;
        shifted     = acc_next >>> s1_shift_q;
    end

    always_comb begin
        clamped = '0;
        if (!s1_mode_q) begin
            if (shifted[ACC_WIDTH-1]) begin
                clamped = '0;
            end else if (shifted > UnsignedMax) begin
                clamped = '1;
            end else begin
                clamped = shifted[OUT_WIDTH-1:0];
            end
        end else begin
            if (shifted > SignedMax) begin
                clamped = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end else if (shifted < SignedMin) begin
                clamped = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            end else begin
                clamped = shifted[OUT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (en) begin
            // Output drains unless a new result lands in the same cycle.
            valid_q <= 1'b0;
            if (s1_valid_q) begin
                if (close_pixel) begin
                    sum_q   <= clamped;
                    valid_q <= 1'b1;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    if (overflow) begin
                        err_q <= 1'b1;
                    end
                end else begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule
